window_fetch: RTL and testbench

Window fetcher that consumes a window anchor address and reads the H_WINDOW_LEN×V_WINDOW_LEN pixel window from a single-port image RAM, one pixel per cycle. It assembles the pixels into one flat window bus for the downstream 5×5 processing stage. It is the read-side counterpart of the window address generator. That generator computes all 25 addresses combinationally; this block issues the same addresses sequentially and collects the returned data.

---
 rtl/window_fetch_pkg.sv | 25 ++
 rtl/window_fetch_if.sv | 28 ++
 rtl/window_offset_cnt.sv | 58 +++++
 rtl/window_fetch.sv | 125 ++++++++++++
 tb/tb_window_fetch.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/window_fetch_pkg.sv
// Shared types and geometry for the window fetcher: image/window sizes,
// FSM state enum, slot index type and the bounds helper.
package window_fetch_pkg;

  localparam int H_WINDOW_LEN = 5;
  localparam int V_WINDOW_LEN = 5;
  localparam int H_IMAGE_LEN  = 35;
  localparam int V_IMAGE_LEN  = 35;
  localparam int PIX_W        = 8;

  localparam int WIN_PIX   = H_WINDOW_LEN * V_WINDOW_LEN;
  localparam int IMAGE_PIX = H_IMAGE_LEN * V_IMAGE_LEN;
  localparam int SLOT_W    = $clog2(WIN_PIX);
  localparam int WIN_W     = PIX_W * WIN_PIX;
  localparam int HCNT_W    = (H_WINDOW_LEN > 1) ? $clog2(H_WINDOW_LEN) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_e;
  typedef logic [SLOT_W-1:0] slot_t;

  // Address of the bottom-right pixel of a window, wrapping modulo 2^32.
  function automatic logic [31:0] win_last_addr(input logic [31:0] anchor);
    return anchor + 32'((V_WINDOW_LEN - 1) * H_IMAGE_LEN + H_WINDOW_LEN - 1);
  endfunction

endpackage

// File: rtl/window_fetch_if.sv
// Anchor handshake, RAM read port and window output of the window fetcher.
// The fetcher is the slave side; the environment/driver is the master side.
interface window_fetch_if;
  import window_fetch_pkg::*;

  logic [31:0]      anchor_addr;
  logic             anchor_valid;
  logic             anchor_ready;
  logic             pause;
  logic [31:0]      mem_addr;
  logic             mem_rd_en;
  logic [PIX_W-1:0] mem_rd_data;
  logic [WIN_W-1:0] win_data;
  logic             win_valid;
  logic             win_ready;
  logic             err;

  modport slave (
    input  anchor_addr, anchor_valid, pause, mem_rd_data, win_ready,
    output anchor_ready, mem_addr, mem_rd_en, win_data, win_valid, err
  );

  modport master (
    output anchor_addr, anchor_valid, pause, mem_rd_data, win_ready,
    input  anchor_ready, mem_addr, mem_rd_en, win_data, win_valid, err
  );

endinterface

// File: rtl/window_offset_cnt.sv
// Column/row walker over the window: h runs fastest, the row offset is an
// accumulator stepping by the image stride so no multiplier is needed.
module window_offset_cnt
  import window_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  output slot_t             slot,
  output logic [HCNT_W-1:0] h,
  output logic [31:0]       row_off,
  output logic              last
);

  localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_WINDOW_LEN - 1);

  logic [HCNT_W-1:0] h_q, h_d;
  logic [31:0]       row_q, row_d;
  slot_t             slot_q, slot_d;

  assign last    = (slot_q == slot_t'(WIN_PIX - 1));
  assign slot    = slot_q;
  assign h       = h_q;
  assign row_off = row_q;

  always_comb begin
    h_d    = h_q;
    row_d  = row_q;
    slot_d = slot_q;
    if (clr || (adv && last)) begin
      h_d    = '0;
      row_d  = '0;
      slot_d = '0;
    end else if (adv) begin
      slot_d = slot_q + slot_t'(1);
      if (h_q == H_LAST) begin
        h_d   = '0;
        row_d = row_q + 32'(H_IMAGE_LEN);
      end else begin
        h_d = h_q + HCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q    <= '0;
      row_q  <= '0;
      slot_q <= '0;
    end else begin
      h_q    <= h_d;
      row_q  <= row_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/window_fetch.sv
// Sequential window fetcher: one RAM read per cycle, captured into a flat window bus.
// Optional anchor bounds check enabled by WINDOW_FETCH_BOUNDS_CHECK_EN.
module window_fetch
  import window_fetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  window_fetch_if.slave bus
);

  state_e            state_q, state_d;
  logic [31:0]       anchor_q;
  logic              cap_en_q;
  slot_t             cap_slot_q;
  logic              accept;
  logic              adv;
  logic              rd_en;
  slot_t             slot;
  logic [HCNT_W-1:0] h;
  logic [31:0]       row_off;
  logic              last;
  logic [PIX_W-1:0]  win_q [WIN_PIX];
  logic [WIN_W-1:0]  win_flat;

  window_offset_cnt u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .adv     (adv),
    .slot    (slot),
    .h       (h),
    .row_off (row_off),
    .last    (last)
  );

`ifdef WINDOW_FETCH_BOUNDS_CHECK_EN
  logic err_q, err_d;
  logic bounds_ok;
  assign bounds_ok = (win_last_addr(bus.anchor_addr) < 32'(IMAGE_PIX));
  assign bus.err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`else
  assign bus.err = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    accept           = 1'b0;
    adv              = 1'b0;
    rd_en            = 1'b0;
    bus.anchor_ready = 1'b0;
    bus.win_valid    = 1'b0;
`ifdef WINDOW_FETCH_BOUNDS_CHECK_EN
    err_d            = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        bus.anchor_ready = 1'b1;
        if (bus.anchor_valid) begin
`ifdef WINDOW_FETCH_BOUNDS_CHECK_EN
          // A rejected anchor is consumed without issuing any read.
          if (bounds_ok) begin
            accept  = 1'b1;
            state_d = FETCH;
          end else begin
            err_d = 1'b1;
          end
`else
          accept  = 1'b1;
          state_d = FETCH;
`endif
        end
      end
      FETCH: begin
        if (!bus.pause) begin
          rd_en = 1'b1;
          adv   = 1'b1;
          if (last) state_d = DRAIN;
        end
      end
      DRAIN: state_d = HOLD;
      HOLD: begin
        bus.win_valid = 1'b1;
        if (bus.win_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = anchor_q + row_off + 32'(h);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      anchor_q   <= '0;
      cap_en_q   <= 1'b0;
      cap_slot_q <= '0;
    end else begin
      state_q    <= state_d;
      if (accept) anchor_q <= bus.anchor_addr;
      cap_en_q   <= rd_en;
      cap_slot_q <= slot;
    end
  end

  // Read data lands one cycle after the strobe; the delayed slot index steers it.
  for (genvar gi = 0; gi < WIN_PIX; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (rst) begin
        win_q[gi] <= '0;
      end else if (cap_en_q && (cap_slot_q == slot_t'(gi))) begin
        win_q[gi] <= bus.mem_rd_data;
      end
    end
    assign win_flat[gi*PIX_W +: PIX_W] = win_q[gi];
  end

  assign bus.win_data = win_flat;

endmodule

// File: tb/tb_window_fetch.sv
// Directed bench for window_fetch: latency, address order, pause, hold, reset,
// and (with WINDOW_FETCH_BOUNDS_CHECK_EN) anchor rejection.
module tb_window_fetch;
  import window_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  window_fetch_if bus();

  window_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single-port RAM model: word at addr holds addr[7:0], registered read.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= bus.mem_addr[7:0];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;
  int t0, nrd, vcyc, ar_bad, pz_bad;
  logic [31:0] rd_addr [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer anchor a in cycle 0, then log reads until win_valid (bounded).
  task automatic fetch(input logic [31:0] a, input int p_at, input int p_len, input logic rdy);
    int rel;
    @(posedge clk); #1;
    chk("ready_idle", 32'(bus.anchor_ready), 1);
    bus.anchor_addr  = a;
    bus.anchor_valid = 1'b1;
    t0 = cyc;
    nrd = 0; vcyc = -1; ar_bad = 0; pz_bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      bus.anchor_valid = 1'b0;
      bus.win_ready    = rdy;
      rel = cyc - t0;
      bus.pause = (rel > p_at) && (rel <= p_at + p_len);
      #1;
      if (bus.win_valid) begin
        vcyc = rel;
        break;
      end
      if (bus.anchor_ready) ar_bad = 1;
      if (bus.pause && bus.mem_rd_en) pz_bad = 1;
      if (bus.mem_rd_en) begin
        if (nrd < 32) rd_addr[nrd] = bus.mem_addr;
        nrd++;
      end
    end
    bus.pause = 1'b0;
  endtask

  task automatic check_window(input logic [31:0] a, input int exp_lat);
    logic [31:0] e;
    chk("n_reads", 32'(nrd), 25);
    chk("latency", 32'(vcyc), 32'(exp_lat));
    chk("ready_busy", 32'(ar_bad), 0);
    chk("read_in_pause", 32'(pz_bad), 0);
    for (int v = 0; v < 5; v++) begin
      for (int h = 0; h < 5; h++) begin
        e = a + 32'(v * 35 + h);
        chk($sformatf("rd_addr[%0d]", v*5+h), rd_addr[v*5+h], e);
        chk($sformatf("slot[%0d]", v*5+h), 32'(bus.win_data[(v*5+h)*8 +: 8]), 32'(e[7:0]));
      end
    end
  endtask

  function automatic logic [WIN_W-1:0] exp_win(input logic [31:0] a);
    logic [31:0] e;
    logic [WIN_W-1:0] w;
    w = '0;
    for (int k = 0; k < 25; k++) begin
      e = a + 32'((k / 5) * 35 + (k % 5));
      w[k*8 +: 8] = e[7:0];
    end
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    bus.anchor_addr  = '0;
    bus.anchor_valid = 1'b0;
    bus.pause        = 1'b0;
    bus.win_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_anchor_ready", 32'(bus.anchor_ready), 1);
    chk("rst_rd_en", 32'(bus.mem_rd_en), 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_win_valid", 32'(bus.win_valid), 0);
    chk("rst_win_zero", 32'(bus.win_data == '0), 1);
    chk("rst_err", 32'(bus.err), 0);
    rst = 1'b0;
    $display("step: reset checked");

    // Anchor 0, no pause
    fetch(32'd0, 0, 0, 1'b1);
    check_window(32'd0, 27);
    $display("step: anchor 0 window done, win_valid at rel cycle %0d", vcyc);

    // Anchor 36, downstream stalls 10 cycles while another anchor is offered
    fetch(32'd36, 0, 0, 1'b0);
    check_window(32'd36, 27);
    for (int i = 0; i < 10; i++) begin
      bus.anchor_addr  = 32'd200;
      bus.anchor_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.win_valid), 1);
      chk("hold_ready_low", 32'(bus.anchor_ready), 0);
      chk("hold_no_read", 32'(bus.mem_rd_en), 0);
      chk("hold_stable", 32'(bus.win_data === exp_win(32'd36)), 1);
    end
    bus.anchor_valid = 1'b0;
    bus.win_ready    = 1'b1;
    @(posedge clk); #1;
    chk("release_ready", 32'(bus.anchor_ready), 1);
    chk("release_valid", 32'(bus.win_valid), 0);
    $display("step: anchor 36 window done with 10-cycle hold");

    // Three pause cycles after the tenth read
    fetch(32'd72, 10, 3, 1'b1);
    check_window(32'd72, 30);
    $display("step: paused window done, win_valid at rel cycle %0d", vcyc);

    // Reset while slot 12 is being issued
    @(posedge clk); #1;
    bus.anchor_addr  = 32'd36;
    bus.anchor_valid = 1'b1;
    repeat (13) begin
      @(posedge clk); #1;
      bus.anchor_valid = 1'b0;
    end
    chk("pre_rst_rd_en", 32'(bus.mem_rd_en), 1);
    chk("pre_rst_addr", bus.mem_addr, 32'd108);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_anchor_ready", 32'(bus.anchor_ready), 1);
    chk("midrst_rd_en", 32'(bus.mem_rd_en), 0);
    chk("midrst_addr", bus.mem_addr, 0);
    chk("midrst_win_valid", 32'(bus.win_valid), 0);
    chk("midrst_win_zero", 32'(bus.win_data == '0), 1);
    chk("midrst_err", 32'(bus.err), 0);
    @(posedge clk); #1;
    chk("postrst_no_capture", 32'(bus.win_data == '0), 1);
    chk("postrst_rd_en", 32'(bus.mem_rd_en), 0);
    fetch(32'd0, 0, 0, 1'b1);
    check_window(32'd0, 27);
    $display("step: mid-fetch reset and refetch done");

`ifdef WINDOW_FETCH_BOUNDS_CHECK_EN
    fetch(32'd1080, 0, 0, 1'b1);
    check_window(32'd1080, 27);
    chk("bounds_last_addr", rd_addr[24], 32'd1224);
    @(posedge clk); #1;
    bus.anchor_addr  = 32'd1081;
    bus.anchor_valid = 1'b1;
    chk("bad_anchor_ready", 32'(bus.anchor_ready), 1);
    chk("bad_no_err_yet", 32'(bus.err), 0);
    @(posedge clk); #1;
    bus.anchor_valid = 1'b0;
    chk("bad_err_pulse", 32'(bus.err), 1);
    chk("bad_no_read", 32'(bus.mem_rd_en), 0);
    chk("bad_ready_kept", 32'(bus.anchor_ready), 1);
    @(posedge clk); #1;
    chk("bad_err_cleared", 32'(bus.err), 0);
    chk("bad_no_read2", 32'(bus.mem_rd_en), 0);
    chk("bad_ready_kept2", 32'(bus.anchor_ready), 1);
    $display("step: bounds check done");
`else
    chk("err_tied_low", 32'(bus.err), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
